// File: rtl/arbitrated_multiplexer.sv
// arbitrated_multiplexer: N-input to one-output multiplexer with a registered valid/ready output stage
// Build option: define ARBITRATED_MULTIPLEXER_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise control_signals fixes the selected input.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   control_signals - input select (fixed-select build only)
//   data/data_valid - N input words with per-input valid
//   data_ready      - per-input ready, one-hot or zero
//   multiplexer_out - registered output word, qualified by out_valid
//   out_valid       - output holds an unconsumed word
//   out_ready       - downstream accepts the word
//   selected        - index of the input that supplied multiplexer_out
module arbitrated_multiplexer #(
    parameter int SELECT_WIDTH = 1,
    parameter int DATA_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SELECT_WIDTH-1:0]     control_signals,
    input  logic [DATA_WIDTH-1:0]       data [2**SELECT_WIDTH-1:0],
    input  logic [2**SELECT_WIDTH-1:0]  data_valid,
    output logic [2**SELECT_WIDTH-1:0]  data_ready,
    output logic [DATA_WIDTH-1:0]       multiplexer_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SELECT_WIDTH-1:0]     selected
);
    localparam int N = 2**SELECT_WIDTH;

    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_out;
    logic [SELECT_WIDTH-1:0] r_sel;
    logic                    w_load;
    logic                    w_any;
    logic                    w_hs;
    logic [SELECT_WIDTH-1:0] w_g;

    assign w_load = !r_valid || out_ready;

`ifdef ARBITRATED_MULTIPLEXER_ROUND_ROBIN_EN
    logic [SELECT_WIDTH-1:0] r_ptr;
    logic [SELECT_WIDTH-1:0] w_idx;

    // Scan offsets from far to near so the nearest valid input after the pointer wins;
    // the offset N truncates to zero, i.e. the pointer itself is tried last.
    always_comb begin
        w_g   = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = r_ptr + SELECT_WIDTH'(i);
            if (data_valid[w_idx]) begin
                w_g   = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= SELECT_WIDTH'(N - 1);
        else if (w_hs)
            r_ptr <= w_g;
    end
`else
    assign w_g   = control_signals;
    assign w_any = data_valid[w_g];
`endif

    assign w_hs       = !reset && w_load && w_any;
    assign data_ready = w_hs ? (N'(1) << w_g) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_sel   <= '0;
        end else if (w_hs) begin
            r_valid <= 1'b1;
            r_out   <= data[w_g];
            r_sel   <= w_g;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid       = r_valid;
    assign multiplexer_out = r_out;
    assign selected        = r_sel;
endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// tb_arbitrated_multiplexer: directed self-checking bench for arbitrated_multiplexer
module tb_arbitrated_multiplexer;
    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] control_signals;
    logic [1:0] data [1:0];
    logic [1:0] data_valid;
    logic [1:0] data_ready;
    logic [1:0] multiplexer_out;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] selected;
    int         checks = 0;
    int         errors = 0;

    arbitrated_multiplexer #(1, 2) dut (
        .clk(clk),
        .reset(reset),
        .control_signals(control_signals),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .multiplexer_out(multiplexer_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .selected(selected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] o, input logic s);
        chk({tag, "_valid"}, 8'(out_valid), 8'(v));
        chk({tag, "_out"}, 8'(multiplexer_out), 8'(o));
        chk({tag, "_sel"}, 8'(selected), 8'(s));
    endtask

    initial begin
        data[0] = 2'b11;
        data[1] = 2'b10;
        reset = 1'b1;
        control_signals = 1'b0;
        data_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        chk("rst_ready", 8'(data_ready), 8'h0);
        step();
        step();
        chk_out("rst", 1'b0, 2'b00, 1'b0);
        chk("rst_ready2", 8'(data_ready), 8'h0);
`ifdef ARBITRATED_MULTIPLEXER_ROUND_ROBIN_EN
        reset = 1'b0;
        control_signals = 1'b1;
        #1;
        chk("rr_ready0", 8'(data_ready), 8'h1);
        step();
        chk_out("rr0", 1'b1, 2'b11, 1'b0);
        chk("rr_ready1", 8'(data_ready), 8'h2);
        step();
        chk_out("rr1", 1'b1, 2'b10, 1'b1);
        step();
        chk_out("rr2", 1'b1, 2'b11, 1'b0);
        step();
        chk_out("rr3", 1'b1, 2'b10, 1'b1);
        data_valid = 2'b00;
        step();
        chk_out("rr_idle", 1'b0, 2'b10, 1'b1);
        data_valid = 2'b01;
        #1;
        chk("rr_ready_single", 8'(data_ready), 8'h1);
        step();
        chk_out("rr_single", 1'b1, 2'b11, 1'b0);
        out_ready = 1'b0;
        data_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("rr_rst_ready", 8'(data_ready), 8'h0);
        step();
        chk_out("rr_rst_full", 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rr_ptr_after_rst", 8'(data_ready), 8'h1);
        step();
        chk_out("rr_post_rst", 1'b1, 2'b11, 1'b0);
`else
        reset = 1'b0;
        #1;
        chk("fx_ready0", 8'(data_ready), 8'h1);
        step();
        chk_out("fx0", 1'b1, 2'b11, 1'b0);
        control_signals = 1'b1;
        #1;
        chk("fx_ready1", 8'(data_ready), 8'h2);
        step();
        chk_out("fx1", 1'b1, 2'b10, 1'b1);
        control_signals = 1'b0;
        step();
        chk_out("bp_load", 1'b1, 2'b11, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            control_signals = ~control_signals;
            #1;
            chk("bp_ready", 8'(data_ready), 8'h0);
            step();
            chk_out("bp_hold", 1'b1, 2'b11, 1'b0);
        end
        out_ready = 1'b1;
        data_valid = 2'b00;
        #1;
        chk("drain_ready", 8'(data_ready), 8'h0);
        step();
        chk_out("drain", 1'b0, 2'b11, 1'b0);
        control_signals = 1'b1;
        data_valid = 2'b01;
        #1;
        chk("inv_ready", 8'(data_ready), 8'h0);
        step();
        chk_out("inv", 1'b0, 2'b11, 1'b0);
        data_valid = 2'b11;
        step();
        chk_out("pre_rst", 1'b1, 2'b10, 1'b1);
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_full_ready", 8'(data_ready), 8'h0);
        step();
        chk_out("rst_full", 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 8'(data_ready), 8'h2);
        step();
        chk_out("post_rst", 1'b1, 2'b10, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
